ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
- Iterative RV32M multiply/divide unit in the EX stage. It consumes operands and the destination register from the ID/EX pipeline register, in parallel with the ALU.
- Holds the pipeline via `stall` while it computes.
- Presents a registered result and `rdAddr` for the EX/MEM register in the cycle `done` is high.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width (must hold XLEN).

Ports:
- clk  input  1  rising-edge clock
- R_n  input  1  asynchronous active-low reset
- start  input  1  M-extension instruction valid in EX (MulDiv_ex from decode)
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  input  XLEN  forwarded rs1 operand
- b  input  XLEN  forwarded rs2 operand
- rdAddr_in  input  5  destination register
- flush  input  1  synchronous kill (branch/jump taken in EX)
- stall  output  1  freeze PC, IF/ID, ID/EX
- busy  output  1  state is not IDLE
- done  output  1  result valid, one cycle
- result  output  XLEN  computed value
- rdAddr_out  output  5  destination of result

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (R_n=0, asynchronous):
  - state=IDLE, counter=0.
  - result=0, rdAddr_out=0, done=0, busy=0.
  - Internal accumulators are zeroed.
- Accept (IDLE, start=1, flush=0), at that edge:
  - latch op and rdAddr_in;
  - latch |a| and |b| per signedness (MULH/DIV/REM signed both; MULHSU a signed only; others unsigned);
  - record the result sign;
  - counter=0; go to RUN.
- Special divides skip RUN and go straight to DONE at the accept edge:
  - b=0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give a.
  - DIV/REM with a=0x80000000, b=0xFFFFFFFF: DIV gives 0x80000000, REM gives 0.
- RUN step, one per edge, counter+1:
  - Multiply: shift-add on a 2*XLEN product.
  - Divide: restoring, one quotient bit per edge.
- RUN exit: on the edge with counter==XLEN-1, load result and go to DONE.
  - Result is sign-corrected.
  - Low word for MUL, high word for MULH*, quotient for DIV*, remainder for REM*.
  - Remainder takes the sign of the dividend.
- DONE: done=1 for exactly one cycle. The next edge returns to IDLE. result and rdAddr_out hold until the next load.
- Latency: the accept edge is E0; done is high between E32 and E33 (33 cycles). Special divides have done high between E0 and E1.
- stall = (state==RUN) | (state==IDLE & start & ~flush). It is combinational, so the ID/EX contents stay frozen while computing. Stall is low in DONE, so the instruction advances to MEM with the result.
- start is ignored in RUN and DONE; no queueing.
- flush: in any state the next edge goes to IDLE with done=0; result and rdAddr_out are unchanged. flush and start together in IDLE: nothing is accepted.
- Reset mid-RUN: immediate IDLE, no done pulse.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: MUL* use a single-cycle combinational XLEN×XLEN product. Accept goes directly to DONE, so done is high between E0 and E1. Divides are unchanged.
- Undefined: all multiplies use the 32-cycle iterative path.

Decomposition:
- Package muldiv_pkg holds:
  - XLEN;
  - funct3 localparams (OP_MUL…OP_REMU);
  - state encoding (S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2);
  - constants DIV0_Q=32'hFFFFFFFF and INT_MIN=32'h80000000.
- One sub-module, div_step: combinational restoring-divide step (remainder, dividend shift in → next remainder, quotient bit). It is instantiated once in ex_muldiv.

Test Plan:
- MUL a=7, b=0xFFFFFFFD → result=0xFFFFFFEB, done 33 cycles after accept, stall high cycles 0–32, rdAddr_out=rdAddr_in.
- MULH a=b=0x80000000 → 0x40000000; MULHU same → 0x40000000; MULHSU a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD; REM same → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
- DIVU a=5, b=0 → 0xFFFFFFFF and REM a=5, b=0 → 5, done at the cycle after accept. DIV 0x80000000/0xFFFFFFFF → 0x80000000.
- flush asserted at counter=10 → IDLE next edge, no done, stall low. A new start 2 cycles later yields a correct result.
- R_n low at counter=20 → all outputs 0 immediately. start during RUN is ignored and the result matches the first operation.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared widths, funct3 codes, FSM states and special-case constants for ex_muldiv
package muldiv_pkg;
    localparam int XLEN = 32;
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
    localparam logic [31:0] DIV0_Q  = 32'hFFFFFFFF;
    localparam logic [31:0] INT_MIN = 32'h80000000;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step producing the next partial remainder and a quotient bit
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic            din,
    input  logic [XLEN-1:0] d,
    output logic [XLEN-1:0] rem_next,
    output logic            q_bit
);
    logic [XLEN:0] sh, diff;
    assign sh       = {rem, din};
    assign diff     = sh - {1'b0, d};
    assign q_bit    = ~diff[XLEN];
    assign rem_next = q_bit ? diff[XLEN-1:0] : sh[XLEN-1:0];
endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit; MULDIV_FAST_MUL_EN selects a single-cycle multiplier
module ex_muldiv #(
    parameter int XLEN  = muldiv_pkg::XLEN,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            R_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rdAddr_in,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rdAddr_out
);
    import muldiv_pkg::*;
    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic              neg;
    logic [XLEN-1:0]   opb;
    logic [2*XLEN-1:0] acc, acc_n, mul_fin;
    logic [XLEN:0]     sum;
    logic [XLEN-1:0]   abs_a, abs_b, rem_n, mul_word, div_word, res_run, special;
    logic              sa, sb, accept, div0, ovf, q_bit;
    assign sa     = a[XLEN-1] & (op == OP_MULH | op == OP_MULHSU | op == OP_DIV | op == OP_REM);
    assign sb     = b[XLEN-1] & (op == OP_MULH | op == OP_DIV | op == OP_REM);
    assign abs_a  = sa ? -a : a;
    assign abs_b  = sb ? -b : b;
    assign div0   = op[2] & (b == '0);
    assign ovf    = (op == OP_DIV | op == OP_REM) & (a == INT_MIN) & (b == DIV0_Q);
    assign special = div0 ? (op[1] ? a : DIV0_Q) : (op[1] ? '0 : INT_MIN);
    assign accept = (state == S_IDLE) & start & ~flush;
    assign stall  = (state == S_RUN) | accept;
    assign busy   = state != S_IDLE;
    assign done   = state == S_DONE;
    // acc holds {product hi, multiplier} for multiplies and {remainder, dividend/quotient} for divides
    div_step #(.XLEN(XLEN)) u_div_step (
        .rem(acc[2*XLEN-1:XLEN]), .din(acc[XLEN-1]), .d(opb), .rem_next(rem_n), .q_bit(q_bit)
    );
    assign sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    assign acc_n    = op_q[2] ? {rem_n, acc[XLEN-2:0], q_bit} : {sum, acc[XLEN-1:1]};
    assign mul_fin  = neg ? -acc_n : acc_n;
    assign mul_word = (op_q[1:0] == 2'b00) ? mul_fin[XLEN-1:0] : mul_fin[2*XLEN-1:XLEN];
    assign div_word = op_q[1] ? acc_n[2*XLEN-1:XLEN] : acc_n[XLEN-1:0];
    assign res_run  = op_q[2] ? (neg ? -div_word : div_word) : mul_word;
`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*XLEN+1:0] prodf;
    assign prodf = $signed({sa, a}) * $signed({sb, b});
`endif
    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            neg        <= 1'b0;
            opb        <= '0;
            acc        <= '0;
            result     <= '0;
            rdAddr_out <= '0;
        end else if (flush) begin
            state <= S_IDLE;
        end else if (state == S_IDLE) begin
            if (start) begin
                op_q <= op;
                rd_q <= rdAddr_in;
                neg  <= (op[2] & op[1]) ? sa : sa ^ sb;
                opb  <= abs_b;
                acc  <= {{XLEN{1'b0}}, abs_a};
                cnt  <= '0;
                if (div0 | ovf) begin
                    result     <= special;
                    rdAddr_out <= rdAddr_in;
                    state      <= S_DONE;
                end
`ifdef MULDIV_FAST_MUL_EN
                else if (!op[2]) begin
                    result     <= (op[1:0] == 2'b00) ? prodf[XLEN-1:0] : prodf[2*XLEN-1:XLEN];
                    rdAddr_out <= rdAddr_in;
                    state      <= S_DONE;
                end
`endif
                else begin
                    state <= S_RUN;
                end
            end
        end else if (state == S_RUN) begin
            acc <= acc_n;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(XLEN - 1)) begin
                result     <= res_run;
                rdAddr_out <= rd_q;
                state      <= S_DONE;
            end
        end else begin
            state <= S_IDLE;
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed scoreboard bench for ex_muldiv
module tb_ex_muldiv;
    import muldiv_pkg::*;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    logic        clk = 1'b0, R_n = 1'b0, start = 1'b0, flush = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0, b = '0;
    logic [4:0]  rdAddr_in = '0;
    logic        stall, busy, done;
    logic [31:0] result;
    logic [4:0]  rdAddr_out;
    int          compared = 0, mismatched = 0;
    logic [36:0] sb_q[$];

    ex_muldiv dut (
        .clk(clk), .R_n(R_n), .start(start), .op(op), .a(a), .b(b),
        .rdAddr_in(rdAddr_in), .flush(flush), .stall(stall), .busy(busy),
        .done(done), .result(result), .rdAddr_out(rdAddr_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [4:0] rd, input logic [31:0] exp,
                          input int lat, input bit intrude);
        int n;
        bit st_ok;
        logic [36:0] e;
        sb_q.push_back({rd, exp});
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; rdAddr_in = rd;
        #1 st_ok = (stall === 1'b1);
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 100) begin
            st_ok &= (stall === 1'b1);
            if (intrude && n == 5) begin
                start = 1'b1; op = OP_MULHU; a = 32'h12345678; b = 32'h9ABCDEF0; rdAddr_in = 5'd31;
            end
            if (intrude && n == 10) start = 1'b0;
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(lat));
        chk({tag, "_stall_busy"}, {31'd0, st_ok}, 32'd1);
        chk({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
        if (done === 1'b1) begin
            e = sb_q.pop_front();
            chk({tag, "_result"}, result, e[31:0]);
            chk({tag, "_rd"}, {27'd0, rdAddr_out}, {27'd0, e[36:32]});
        end
        @(negedge clk);
        chk({tag, "_done_clear"}, {31'd0, done}, 32'd0);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_result", result, 32'd0);
        chk("rst_rd", {27'd0, rdAddr_out}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        R_n = 1'b1;

        run_op("mul",    OP_MUL,    32'd7,          32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, MUL_LAT, 1'b0);
        run_op("mulh",   OP_MULH,   32'h80000000,   32'h80000000, 5'd4,  32'h40000000, MUL_LAT, 1'b0);
        run_op("mulhu",  OP_MULHU,  32'h80000000,   32'h80000000, 5'd5,  32'h40000000, MUL_LAT, 1'b0);
        run_op("mulhsu", OP_MULHSU, 32'hFFFFFFFF,   32'd2,        5'd6,  32'hFFFFFFFF, MUL_LAT, 1'b0);
        run_op("div",    OP_DIV,    32'hFFFFFFF9,   32'd2,        5'd7,  32'hFFFFFFFD, 33, 1'b0);
        run_op("rem",    OP_REM,    32'hFFFFFFF9,   32'd2,        5'd8,  32'hFFFFFFFF, 33, 1'b0);
        run_op("divu",   OP_DIVU,   32'd100,        32'd7,        5'd9,  32'd14,       33, 1'b0);
        run_op("remu",   OP_REMU,   32'd100,        32'd7,        5'd10, 32'd2,        33, 1'b0);
        run_op("divu0",  OP_DIVU,   32'd5,          32'd0,        5'd11, 32'hFFFFFFFF, 1,  1'b0);
        run_op("rem0",   OP_REM,    32'd5,          32'd0,        5'd12, 32'd5,        1,  1'b0);
        run_op("divovf", OP_DIV,    32'h80000000,   32'hFFFFFFFF, 5'd13, 32'h80000000, 1,  1'b0);
        run_op("removf", OP_REM,    32'h80000000,   32'hFFFFFFFF, 5'd14, 32'd0,        1,  1'b0);

        // flush a divide part-way through; outputs must keep the previous result
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd3; rdAddr_in = 5'd20;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        chk("flush_busy_before", {31'd0, busy}, 32'd1);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_done", {31'd0, done}, 32'd0);
        chk("flush_stall", {31'd0, stall}, 32'd0);
        chk("flush_result_held", result, 32'd0);
        chk("flush_rd_held", {27'd0, rdAddr_out}, 32'd14);
        repeat (2) @(negedge clk);
        run_op("after_flush", OP_DIVU, 32'd100, 32'd7, 5'd15, 32'd14, 33, 1'b0);

        // asynchronous reset mid-run
        @(negedge clk);
        start = 1'b1; op = OP_MUL; a = 32'd3; b = 32'd5; rdAddr_in = 5'd16;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        R_n = 1'b0;
        #1;
        chk("arst_result", result, 32'd0);
        chk("arst_rd", {27'd0, rdAddr_out}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        R_n = 1'b1;

        run_op("start_in_run", OP_MUL, 32'd123, 32'd456, 5'd17, 32'h0000DB18, MUL_LAT, 1'b1);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
